// File: rtl/result_tx_buffer.sv
// Result matrix buffer with a UART 8N1 dump port.
// Elements are written by index; a rising edge on read_R_mat streams every word out
// as two frames, high byte first, starting at element 0.
module result_tx_buffer #(
    parameter int unsigned ROW          = 10,
    parameter int unsigned COLUMN       = 10,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_R,
    input  logic [31:0] write_address_R,
    input  logic [15:0] write_value_R,
    input  logic        read_R_mat,
    output logic        tx_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned Depth  = ROW * COLUMN;
    localparam int unsigned IdxW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [IdxW-1:0]   LastIdx  = IdxW'(Depth - 1);
    localparam logic [TimerW-1:0] LastTick = TimerW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStartBit,
        StDataBits,
        StStopBit,
        StNext,
        StDone
    } state_e;

    logic [15:0]       mem_q [Depth];
    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic              sel_hi_q;
    logic [7:0]        shift_q;
    logic [2:0]        bit_q;
    logic [TimerW-1:0] timer_q;
    logic              read_q;
    logic              read_prev_q;

    logic req_rise;
    logic wr_en;
    logic bit_end;

    // Request is registered first, so the edge is seen one cycle after it is sampled.
    assign req_rise = read_q & ~read_prev_q;
    // Out-of-range indices are dropped rather than wrapped onto low words.
    assign wr_en    = write_R && (write_address_R < 32'(Depth));
    assign bit_end  = (timer_q == LastTick);

    // Result storage: cleared by reset, writable in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            mem_q[write_address_R[IdxW-1:0]] <= write_value_R;
        end
    end

    // Dump FSM with request edge detector and registered serial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            sel_hi_q    <= 1'b1;
            shift_q     <= '0;
            bit_q       <= '0;
            timer_q     <= '0;
            read_q      <= 1'b0;
            read_prev_q <= 1'b0;
            tx_data     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            read_q      <= read_R_mat;
            read_prev_q <= read_q;
            unique case (state_q)
                StIdle, StDone: begin
                    tx_data <= 1'b1;
                    if (req_rise) begin
                        state_q  <= StLoad;
                        idx_q    <= '0;
                        sel_hi_q <= 1'b1;
                        timer_q  <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                StLoad: begin
                    // Same-cycle write lands after this read, so the old word is sent.
                    shift_q <= sel_hi_q ? mem_q[idx_q][15:8] : mem_q[idx_q][7:0];
                    tx_data <= 1'b0;
                    timer_q <= '0;
                    state_q <= StStartBit;
                end
                StStartBit: begin
                    if (bit_end) begin
                        timer_q <= '0;
                        bit_q   <= '0;
                        tx_data <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= StDataBits;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StDataBits: begin
                    if (bit_end) begin
                        timer_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_data <= 1'b1;
                            state_q <= StStopBit;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_data <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StStopBit: begin
                    tx_data <= 1'b1;
                    if (bit_end) begin
                        timer_q <= '0;
                        state_q <= StNext;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StNext: begin
                    tx_data <= 1'b1;
                    if (sel_hi_q) begin
                        sel_hi_q <= 1'b0;
                        state_q  <= StLoad;
                    end else if (idx_q != LastIdx) begin
                        idx_q    <= idx_q + 1'b1;
                        sel_hi_q <= 1'b1;
                        state_q  <= StLoad;
                    end else begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    tx_data <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/result_tx_buffer.md
RESULT_TX_BUFFER -- requirements
Module: result_tx_buffer

Interface
- REQ-001: Parameter ROW, default 10, number of result-matrix rows.
- REQ-002: Parameter COLUMN, default 10, number of result-matrix columns.
- REQ-003: Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit.
- REQ-004: clk  input  1  single clock; all logic on its rising edge.
- REQ-005: rst  input  1  reset, synchronous and active-high.
- REQ-006: write_R  input  1  write strobe for one result element.
- REQ-007: write_address_R  input  32  element index, row*COLUMN+col.
- REQ-008: write_value_R  input  16  result element value.
- REQ-009: read_R_mat  input  1  dump request, level, held high by the controller.
- REQ-010: tx_data  output  1  UART 8N1 serial line, idle high.
- REQ-011: busy  output  1  high while a dump is in progress.
- REQ-012: done  output  1  sticky flag: the last dump finished.

Function
- REQ-013: Storage SHALL be ROW*COLUMN words of 16 bits.
- REQ-014: A write with write_R=1 and address < ROW*COLUMN SHALL update that word at the clock edge.
- REQ-015: Writes with address >= ROW*COLUMN SHALL be ignored, with no wrap-around.
- REQ-016: Writes SHALL be accepted in every state, including during a dump.
- REQ-017: A dump SHALL start only on a rising edge of read_R_mat (previous sample 0, current sample 1) while in IDLE or DONE. Holding the line high SHALL NOT retrigger a dump.
- REQ-018: A rising edge of read_R_mat during a dump SHALL be ignored.
- REQ-019: The FSM SHALL have the states IDLE, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT and DONE.
- REQ-020: IDLE/DONE -> LOAD on the request edge. On that edge: element index = 0, byte select = high, busy=1, done=0.
- REQ-021: In LOAD the block SHALL latch the selected byte of the indexed word (high byte [15:8] first, then low byte [7:0]), then go to START_BIT.
- REQ-022: Read-during-write to the same address in the LOAD cycle SHALL return the old value.
- REQ-023: START_BIT SHALL drive tx_data=0 for CLKS_PER_BIT cycles.
- REQ-024: DATA_BITS SHALL drive 8 bits LSB first, each for CLKS_PER_BIT cycles.
- REQ-025: STOP_BIT SHALL drive tx_data=1 for CLKS_PER_BIT cycles, then go to NEXT.
- REQ-026: NEXT, if the byte was high: select low -> LOAD.
- REQ-027: NEXT, if the byte was low and index < ROW*COLUMN-1: index+1, select high -> LOAD.
- REQ-028: NEXT, otherwise: -> DONE with busy=0 and done=1.
- REQ-029: Latency: request edge sampled at edge N; tx_data=0 from edge N+2. There SHALL be exactly 2 idle-high cycles (NEXT, LOAD) between a stop bit and the next start bit.
- REQ-030: A full dump SHALL be 2*ROW*COLUMN frames, i.e. 200 at the defaults.
- REQ-031: done SHALL remain 1 until rst or the next request edge.
- REQ-032: tx_data SHALL be 1 in IDLE, LOAD, NEXT and DONE.
- REQ-033: The bit timer SHALL count 0..CLKS_PER_BIT-1 and reload per bit, with no drift.

Reset
- REQ-034: On rst=1 at a clock edge: state=IDLE, tx_data=1, busy=0, done=0, index=0, bit timer=0, and the read_R_mat edge-detect register cleared.
- REQ-035: On reset, all memory words SHALL be 0.
- REQ-036: rst mid-dump SHALL abort the frame immediately, with tx_data=1 at the next edge; no partial retransmission after release.
- REQ-037: rst takes priority over a write_R issued in the same cycle; that write is discarded.

Verification (CLKS_PER_BIT=4, ROW=COLUMN=2 unless stated)
- REQ-038: Write 0x1234 to address 0, raise read_R_mat. Required: first frame 0x12, second 0x34, start bit at edge N+2, each bit exactly 4 cycles.
- REQ-039: Fill addresses 0..3 with 0x0001, 0x00FF, 0xABCD, 0xFFFF, then dump. Required: bytes 00 01 00 FF AB CD FF FF, done=1 after the last stop bit, busy=0.
- REQ-040: Hold read_R_mat high for 200 cycles after done. Required: no second dump. Then drop it and raise it again. Required: an identical second dump.
- REQ-041: Write address 4 with 0xDEAD, then dump. Required: memory unchanged, output 00 00 x4 words.
- REQ-042: Assert rst during data bit 3 of the second frame. Required: tx_data=1, busy=0, done=0 next edge, and all words read 0 on the next dump.
- REQ-043: During the high-byte frame of word 1, write word 1 = 0x5555 (old 0x1111). Required: bytes 11 55 sent for word 1 (low byte loaded after the write).
